// File: rtl/snake_score_pkg.sv
// Shared definitions for the snake score path: adder width, per-event point
// width, saturation value and the accumulator state encoding. Also used by
// the display and speed-control blocks.
package snake_score_pkg;

  localparam int SCORE_W = 20;
  localparam int PTS_W   = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 20'hF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    CHECK = 2'd2,
    LVL   = 2'd3
  } state_t;

  // The shared adder has no carry-out, so a sum smaller than its base
  // operand means the addition wrapped; clamp to the largest score instead.
  function automatic logic [SCORE_W-1:0] sat_sum(
    input logic [SCORE_W-1:0] sum,
    input logic [SCORE_W-1:0] base
  );
    logic [SCORE_W-1:0] res;
    if (sum < base) begin
      res = SCORE_MAX;
    end else begin
      res = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/snake_score_accumulator.sv
// Running-score engine for the snake game. Accepts apple-eaten point events,
// adds them to the score through the shared external 20-bit adder (operands
// held SETTLE cycles before the sum is captured), saturates on overflow and
// advances the level each time the score reaches the next threshold, reusing
// the same adder to step the threshold.
// Optional feature: define SNAKE_HIGH_SCORE_EN to keep a best-score register
// (updated in every CHECK cycle, preserved across clear, reset only by rst).
module snake_score_accumulator
  import snake_score_pkg::*;
#(
  parameter int SETTLE     = 2,
  parameter int LEVEL_STEP = 100,
  parameter int MAX_LEVEL  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               evt_valid,
  input  logic [PTS_W-1:0]   evt_points,
  output logic               evt_ready,
  output logic [SCORE_W-1:0] add_a,
  output logic [SCORE_W-1:0] add_b,
  input  logic [SCORE_W-1:0] add_s,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic               level_up,
  output logic               busy,
  output logic [SCORE_W-1:0] hi_score
);

  localparam int                 CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SCORE_W-1:0] STEP     = SCORE_W'(LEVEL_STEP);
  localparam logic [3:0]         LVL_MAX  = 4'(MAX_LEVEL);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SCORE_W-1:0] next_lvl;

  assign evt_ready = (state == IDLE) && !clear;
  assign busy      = (state != IDLE);

  // Event sequencing: operand drive, settle counting, sum capture and level stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      score    <= '0;
      level    <= 4'd0;
      next_lvl <= STEP;
      level_up <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
    end else if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      score    <= '0;
      level    <= 4'd0;
      next_lvl <= STEP;
      level_up <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
    end else begin
      level_up <= 1'b0;
      case (state)
        IDLE: begin
          // Zero-point events are consumed here without starting an add.
          if (evt_valid && (evt_points != {PTS_W{1'b0}})) begin
            state <= SUM;
            cnt   <= '0;
            add_a <= score;
            add_b <= {{(SCORE_W-PTS_W){1'b0}}, evt_points};
          end else begin
            state <= IDLE;
          end
        end
        SUM: begin
          if (cnt == CNT_LAST) begin
            score <= sat_sum(add_s, add_a);
            add_a <= '0;
            add_b <= '0;
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          // One level per pass; LVL returns here so a big event can cross several.
          if ((score >= next_lvl) && (level < LVL_MAX)) begin
            level_up <= 1'b1;
            level    <= level + 4'd1;
            add_a    <= next_lvl;
            add_b    <= STEP;
            cnt      <= '0;
            state    <= LVL;
          end else begin
            state <= IDLE;
          end
        end
        LVL: begin
          if (cnt == CNT_LAST) begin
            next_lvl <= sat_sum(add_s, add_a);
            add_a    <= '0;
            add_b    <= '0;
            cnt      <= '0;
            state    <= CHECK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          add_a <= '0;
          add_b <= '0;
        end
      endcase
    end
  end

`ifdef SNAKE_HIGH_SCORE_EN
  // Best-score tracking: plain magnitude compare, kept across game restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_score <= '0;
    end else if (!clear && (state == CHECK) && (score > hi_score)) begin
      hi_score <= score;
    end else begin
      hi_score <= hi_score;
    end
  end
`else
  assign hi_score = '0;
`endif

endmodule

// File: tb/tb_snake_score_accumulator.sv
// Self-checking bench for snake_score_accumulator: randomized point events,
// a points-level reference model, and a scoreboard queue drained by a
// monitor each time the DUT finishes an event (busy falls).
module tb_snake_score_accumulator;
  import snake_score_pkg::*;

  localparam int MAXV = 1048575;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               evt_valid = 1'b0;
  logic [PTS_W-1:0]   evt_points = '0;
  logic               evt_ready;
  logic [SCORE_W-1:0] add_a, add_b, add_s;
  logic [SCORE_W-1:0] score;
  logic [3:0]         level;
  logic               level_up;
  logic               busy;
  logic [SCORE_W-1:0] hi_score;

  // The shared adder lives outside the block.
  assign add_s = add_a + add_b;

  snake_score_accumulator #(.SETTLE(2), .LEVEL_STEP(100), .MAX_LEVEL(15)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .evt_valid(evt_valid), .evt_points(evt_points), .evt_ready(evt_ready),
    .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .score(score), .level(level), .level_up(level_up),
    .busy(busy), .hi_score(hi_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    int level;
    int ups;
    int hi;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_score = 0, m_level = 0, m_next = 100, m_hi = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int hi_exp();
`ifdef SNAKE_HIGH_SCORE_EN
    return m_hi;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset_game();
    m_score = 0;
    m_level = 0;
    m_next  = 100;
  endtask

  // Apply one event to the model and queue the expected end-of-event result.
  task automatic model_event(input int p);
    exp_t e;
    int ups;
    if (p == 0) return;
    m_score = m_score + p;
    if (m_score > MAXV) m_score = MAXV;
    ups = 0;
    while (m_level < 15 && m_score >= m_next) begin
      m_level++;
      ups++;
      m_next = (m_next + 100 > MAXV) ? MAXV : m_next + 100;
    end
    if (m_score > m_hi) m_hi = m_score;
    e.score = m_score;
    e.level = m_level;
    e.ups   = ups;
    e.hi    = hi_exp();
    q.push_back(e);
  endtask

  // Offer one event; returns at 1ns after the accepting edge.
  task automatic send(input int p);
    int n;
    @(negedge clk);
    evt_valid  = 1'b1;
    evt_points = PTS_W'(p);
    n = 0;
    while (!evt_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("accept_timeout", 0, 1);
      evt_valid = 1'b0;
    end else begin
      model_event(p);
      @(posedge clk);
      #1;
      evt_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 0, 1);
  endtask

  // Restart while idle: ready must drop with clear, game state returns to zero.
  task automatic do_clear();
    wait_idle();
    clear = 1'b1;
    #1;
    check("ready_low_during_clear", int'(evt_ready), 0);
    @(negedge clk);
    clear = 1'b0;
    model_reset_game();
    check("clear_score", int'(score), 0);
    check("clear_level", int'(level), 0);
    check("clear_hi", int'(hi_score), hi_exp());
  endtask

  // Restart during the first SUM cycle: the event is lost, best score untouched.
  task automatic send_clear_mid(input int p);
    int saved_hi;
    exp_t e;
    saved_hi = m_hi;
    send(p);
    @(negedge clk);
    clear = 1'b1;
    void'(q.pop_back());
    model_reset_game();
    m_hi    = saved_hi;
    e.score = 0;
    e.level = 0;
    e.ups   = 0;
    e.hi    = hi_exp();
    q.push_back(e);
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Monitor: counts level_up pulses and scores each completed event.
  initial begin
    bit prev_busy;
    int ups;
    exp_t e;
    prev_busy = 1'b0;
    ups = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        ups = 0;
      end else begin
        if (level_up) ups++;
        if (prev_busy && !busy) begin
          if (q.size() == 0) begin
            check("unexpected_completion", 1, 0);
          end else begin
            e = q.pop_front();
            check("score", int'(score), e.score);
            check("level", int'(level), e.level);
            check("level_up_count", ups, e.ups);
            check("hi_score", int'(hi_score), e.hi);
          end
          ups = 0;
        end
        prev_busy = busy;
      end
    end
  end

  // Watchdog bounding total run time.
  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    // Reset state
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_score", int'(score), 0);
    check("rst_level", int'(level), 0);
    check("rst_add_a", int'(add_a), 0);
    check("rst_add_b", int'(add_b), 0);
    check("rst_level_up", int'(level_up), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(evt_ready), 1);
    check("rst_hi", int'(hi_score), 0);

    // Single small event: operands held two cycles, ready low three cycles
    send(5);
    @(negedge clk);
    check("t1_sum1_add_a", int'(add_a), 0);
    check("t1_sum1_add_b", int'(add_b), 5);
    check("t1_sum1_ready", int'(evt_ready), 0);
    @(negedge clk);
    check("t1_sum2_add_b", int'(add_b), 5);
    check("t1_sum2_ready", int'(evt_ready), 0);
    @(negedge clk);
    check("t1_check_ready", int'(evt_ready), 0);
    check("t1_check_add_b", int'(add_b), 0);
    check("t1_check_score", int'(score), 5);
    @(negedge clk);
    check("t1_ready_back", int'(evt_ready), 1);

    // 60 + 50 crosses the first threshold once; next threshold is 200
    do_clear();
    send(60);
    send(50);
    send(89);
    send(1);

    // 255 from zero crosses two thresholds
    do_clear();
    send(255);

    // Event lost to a restart in flight
    send_clear_mid(40);
    send(7);

    // Random mix of events, zero-point events and restarts
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do_clear();
      end else if (r < 8) begin
        send_clear_mid(int'($urandom_range(1, 255)));
      end else if (r < 16) begin
        send(0);
      end else begin
        send(int'($urandom_range(1, 255)));
      end
    end

    // Drive the score to 0xFFFF0 and overflow it
    do_clear();
    for (int i = 0; i < 4112; i++) send(255);
    wait_idle();
    check("sat_pre_score", int'(score), 32'h000F_FFF0);
    send(32);
    send(7);
    wait_idle();
    check("sat_score", int'(score), MAXV);
    check("sat_level", int'(level), 15);

    // Async reset during a level step
    do_clear();
    send(255);
    n = 0;
    @(negedge clk);
    while (!level_up && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("level_up_timeout", 0, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    if (q.size() != 0) void'(q.pop_back());
    model_reset_game();
    m_hi = 0;
    #1;
    check("arst_score", int'(score), 0);
    check("arst_level", int'(level), 0);
    check("arst_add_a", int'(add_a), 0);
    check("arst_add_b", int'(add_b), 0);
    check("arst_level_up", int'(level_up), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_hi", int'(hi_score), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("arst_ready_after", int'(evt_ready), 1);
    send(120);

    wait_idle();
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
